mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/mem_stage_if.sv | 49 ++++
 rtl/mem_stage_load_ext.sv | 28 ++
 rtl/mem_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access sizes,
// FSM states and the alignment-fault predicate.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      SZ_WORD: m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bus between EX/MEM and the memory stage, plus
// debug read port and status outputs.
interface mem_stage_if #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) ();

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      i_ALUAddress;
  logic [31:0]      i_Write_data;
  logic             i_MemRead;
  logic             i_MemWrite;
  logic [1:0]       i_Size;
  logic             i_Unsigned;
  logic             i_Halt;
  logic [AW-1:0]    i_Dbg_addr;

  logic [31:0]      o_Read_data;
  logic [31:0]      o_Dbg_data;
  logic             o_Ready;
  logic             o_Misalign;
  logic [31:0]      o_Fault_addr;
  logic             o_Halted;
  logic [CNT_W-1:0] o_Store_count;

  modport master (
    output i_ALUAddress, i_Write_data,
    output i_MemRead, i_MemWrite,
    output i_Size, i_Unsigned,
    output i_Halt, i_Dbg_addr,
    input  o_Read_data, o_Dbg_data,
    input  o_Ready, o_Misalign,
    input  o_Fault_addr, o_Halted,
    input  o_Store_count
  );

  modport slave (
    input  i_ALUAddress, i_Write_data,
    input  i_MemRead, i_MemWrite,
    input  i_Size, i_Unsigned,
    input  i_Halt, i_Dbg_addr,
    output o_Read_data, o_Dbg_data,
    output o_Ready, o_Misalign,
    output o_Fault_addr, o_Halted,
    output o_Store_count
  );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Load lane select and sign/zero extension for
// byte, half and word accesses (little-endian).
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = 8'(word >> {off, 3'b000});
    h    = off[1] ? word[31:16] : word[15:0];
    data = '0;
    unique case (1'b1)
      (size == SZ_BYTE): data = {{24{~uns & b[7]}}, b};
      (size == SZ_HALF): data = {{16{~uns & h[15]}}, h};
      (size == SZ_WORD): data = word;
      default:           data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: zero-initialised data array with byte-lane
// stores, extended loads, fault capture and halt tracking.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input logic      clk,
  input logic      rst,
  mem_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  state_t           state;
  logic [AW-1:0]    ptr;
  logic             halted;
  logic             misalign;
  logic [31:0]      fault_addr;
  logic [CNT_W-1:0] cnt;

  logic [AW-1:0]    widx;
  logic [1:0]       off;
  logic             run;
  logic             fault;
  logic             store_ok;
  logic             load_ok;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [AW-1:0]    we_idx;
  logic [3:0]       we_be;
  logic [31:0]      we_data;
  logic [31:0]      rd_word;
  logic [31:0]      ext;

  assign widx = bus.i_ALUAddress[AW+1:2];
  assign off  = bus.i_ALUAddress[1:0];
  assign run  = (state == ST_RUN);

  assign fault = run
    && (bus.i_MemRead || bus.i_MemWrite)
    && misaligned(bus.i_Size, off);

  assign store_ok = run && bus.i_MemWrite
    && !fault && !halted;

  assign load_ok = run && bus.i_MemRead
    && !bus.i_MemWrite && !fault;

  always_comb begin
    be    = '0;
    wdata = '0;
    unique case (1'b1)
      (bus.i_Size == SZ_BYTE): begin
        be    = 4'b0001 << off;
        wdata = {4{bus.i_Write_data[7:0]}};
      end
      (bus.i_Size == SZ_HALF): begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.i_Write_data[15:0]}};
      end
      (bus.i_Size == SZ_WORD): begin
        be    = 4'b1111;
        wdata = bus.i_Write_data;
      end
      default: begin
        be    = '0;
        wdata = '0;
      end
    endcase
  end

  // One write port shared by the clear sweep and stores
  always_comb begin
    we_idx  = run ? widx : ptr;
    we_data = run ? wdata : '0;
    we_be   = '0;
    if (rst) begin
      if (!run)
        we_be = 4'b1111;
      else if (store_ok)
        we_be = be;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_be[b])
        mem[we_idx][8*b +: 8] <= we_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_CLEAR;
      ptr        <= '0;
      halted     <= 1'b0;
      misalign   <= 1'b0;
      fault_addr <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (&ptr)
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.i_Halt)
            halted <= 1'b1;
          if (fault) begin
            misalign <= 1'b1;
            if (!misalign)
              fault_addr <= bus.i_ALUAddress;
          end
          if (store_ok && !(&cnt))
            cnt <= cnt + 1'b1;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign rd_word = mem[widx];

  load_ext u_load_ext (
    .word (rd_word),
    .off  (off),
    .size (bus.i_Size),
    .uns  (bus.i_Unsigned),
    .data (ext)
  );

  assign bus.o_Read_data   = load_ok ? ext : '0;
  assign bus.o_Dbg_data    = mem[bus.i_Dbg_addr];
  assign bus.o_Ready       = run;
  assign bus.o_Misalign    = misalign;
  assign bus.o_Fault_addr  = fault_addr;
  assign bus.o_Halted      = halted;
  assign bus.o_Store_count = cnt;

endmodule
